// File: rtl/buck_ctrl_sync.sv
// Buck converter switching controller.
// Synchronizes the UV / over-current / zero-crossing comparator flags and
// sequences the PMOS and NMOS switch enables with break-before-make dead
// time, min/max on-time limits and a sticky runaway fault.
module buck_ctrl_sync #(
  parameter int SYNC_STAGES = 2,   // flops per async input, >= 2
  parameter int DEAD_CYC    = 2,   // both-off cycles between switch phases, >= 1
  parameter int MIN_ON_CYC  = 4,   // on-cycles before oc/zc may end a phase, >= 1
  parameter int MAX_ON_CYC  = 64,  // forced phase end, > MIN_ON_CYC
  parameter int CNT_W       = 8,   // phase counter width, must hold MAX_ON_CYC
  parameter int FAULT_LIMIT = 4    // consecutive max-on PMOS phases that trip fault
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic uv,
  input  logic oc,
  input  logic zc,
  output logic p_on,
  output logic n_on,
  output logic fault,
  output logic busy
);

  localparam int FCNT_W = $clog2(FAULT_LIMIT + 1);

  localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0]  MIN_LAST  = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0]  MAX_LAST  = CNT_W'(MAX_ON_CYC - 1);
  localparam logic [FCNT_W-1:0] FAULT_MAX = FCNT_W'(FAULT_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAD_P,
    S_P_ON,
    S_DEAD_N,
    S_N_ON
  } state_t;

  // What happens to the runaway bookkeeping on this edge.
  typedef enum logic [1:0] {
    FC_HOLD,   // leave fault counter and fault alone
    FC_CLR,    // healthy oc-terminated phase: restart the run count
    FC_INC,    // max-on phase: count it, maybe trip fault
    FC_RESET   // disabled in IDLE: clear count and the sticky fault
  } fcnt_op_t;

  logic [SYNC_STAGES-1:0] uv_sync, oc_sync, zc_sync;
  logic                   uv_s, oc_s, zc_s;

  state_t                 state, state_nxt;
  fcnt_op_t               fcnt_op;
  logic [CNT_W-1:0]       cnt;
  logic [FCNT_W-1:0]      fcnt, fcnt_inc;

  // Shift each comparator flag through its synchronizer chain.
  // NOTE: non-blocking assignments make every flop sample the pre-edge value,
  // which is what turns this into a chain rather than a single wire.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      uv_sync <= '0;
      oc_sync <= '0;
      zc_sync <= '0;
    end else begin
      uv_sync <= {uv_sync[SYNC_STAGES-2:0], uv};
      oc_sync <= {oc_sync[SYNC_STAGES-2:0], oc};
      zc_sync <= {zc_sync[SYNC_STAGES-2:0], zc};
    end
  end

  assign uv_s = uv_sync[SYNC_STAGES-1];
  assign oc_s = oc_sync[SYNC_STAGES-1];
  assign zc_s = zc_sync[SYNC_STAGES-1];

  // Saturating increment of the consecutive max-on phase count.
  assign fcnt_inc = (fcnt == FAULT_MAX) ? fcnt : fcnt + 1'b1;

  // Next-state and fault-bookkeeping decision from the synchronized flags.
  // NOTE: every variable gets a default before the case, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    fcnt_op   = FC_HOLD;
    unique case (state)
      S_IDLE: begin
        if (en && uv_s && !fault) begin
          state_nxt = S_DEAD_P;
        end else if (!en) begin
          fcnt_op = FC_RESET;
        end
      end
      S_DEAD_P: begin
        if (!en) begin
          state_nxt = S_IDLE;
        end else if (cnt == DEAD_LAST) begin
          state_nxt = S_P_ON;
        end
      end
      S_P_ON: begin
        // oc is tested before max-on so a coincident oc counts as healthy.
        if (!en) begin
          state_nxt = S_DEAD_N;
        end else if (oc_s && (cnt >= MIN_LAST)) begin
          state_nxt = S_DEAD_N;
          fcnt_op   = FC_CLR;
        end else if (cnt == MAX_LAST) begin
          state_nxt = S_DEAD_N;
          fcnt_op   = FC_INC;
        end
      end
      S_DEAD_N: begin
        // en is ignored from here on so the inductor always discharges.
        if (cnt == DEAD_LAST) begin
          state_nxt = S_N_ON;
        end
      end
      S_N_ON: begin
        if ((zc_s && (cnt >= MIN_LAST)) || (cnt == MAX_LAST)) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, phase counter, fault tracking and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      cnt   <= '0;
      fcnt  <= '0;
      fault <= 1'b0;
      p_on  <= 1'b0;
      n_on  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      // The counter restarts on every state entry; wrap in IDLE is harmless.
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
      // Outputs decode the next state so they change on the same edge.
      p_on  <= (state_nxt == S_P_ON);
      n_on  <= (state_nxt == S_N_ON);
      busy  <= (state_nxt != S_IDLE);
      unique case (fcnt_op)
        FC_CLR: fcnt <= '0;
        FC_INC: begin
          fcnt <= fcnt_inc;
          if (fcnt_inc == FAULT_MAX) begin
            fault <= 1'b1;
          end
        end
        FC_RESET: begin
          fcnt  <= '0;
          fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
